h2c_marker_ctrl: RTL and testbench

- Sequences H2C marker requests into the descriptor-bypass interface on behalf of CSR/software.
- Per request: captures the target queue and engine (MM or ST), holds off normal bypass descriptors, and drives the marker request until the engine accepts it. It then waits for the matching marker response, or times out.
- Reports busy/done/timeout status, the measured request-to-response latency, and a completion count.
- Sits between the CSR block and the H2C descriptor-bypass steering logic.

---
 rtl/h2c_marker_ctrl.sv | 154 +++++++++++++++
 tb/tb_h2c_marker_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/h2c_marker_ctrl.sv
// H2C marker request sequencer.
// Takes a CSR start pulse and captures the target queue and engine. It then
// fences normal bypass descriptors for one cycle and presents a marker
// request to the chosen engine until that engine accepts it. Finally it waits
// for the matching marker response, or abandons the operation after TIMEOUT
// cycles. Every output is driven straight from a flop.
module h2c_marker_ctrl #(
  parameter int          CNT_W   = 16,
  parameter int unsigned TIMEOUT = 16'hFFFF
) (
  input  logic             axi_aclk,
  input  logic             axi_aresetn,
  input  logic             csr_mrkr_start,
  input  logic             csr_mrkr_st_mm,
  input  logic [10:0]      csr_mrkr_qid,
  output logic             csr_mrkr_busy,
  output logic             csr_mrkr_done,
  output logic             csr_mrkr_timeout,
  output logic [CNT_W-1:0] csr_mrkr_latency,
  output logic [CNT_W-1:0] csr_mrkr_cnt,
  output logic             h2c_mm_marker_req,
  output logic             h2c_st_marker_req,
  output logic [10:0]      h2c_mrkr_qid,
  output logic             h2c_dsc_byp_hold,
  input  logic             h2c_byp_in_mm_rdy,
  input  logic             h2c_byp_in_st_rdy,
  input  logic             h2c_mm_marker_rsp,
  input  logic             h2c_st_marker_rsp
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_HOLD     = 2'd1,
    S_REQ      = 2'd2,
    S_WAIT_RSP = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);

  state_t           r_state;
  logic             r_st_mm;     // 1 = MM engine, 0 = ST engine
  logic [10:0]      r_qid;
  logic [CNT_W-1:0] r_tmr;
  logic             r_busy;
  logic             r_done;
  logic             r_timeout;
  logic [CNT_W-1:0] r_latency;
  logic [CNT_W-1:0] r_cnt;
  logic             r_mm_req;
  logic             r_st_req;
  logic             r_hold;

  logic             w_sel_rdy;
  logic             w_sel_rsp;
  logic             w_tmo;
  logic [CNT_W-1:0] w_tmr_inc;

  // Only the captured engine's handshakes matter; the other engine is ignored.
  assign w_sel_rdy = r_st_mm ? h2c_byp_in_mm_rdy : h2c_byp_in_st_rdy;
  assign w_sel_rsp = r_st_mm ? h2c_mm_marker_rsp : h2c_st_marker_rsp;
  assign w_tmo     = (r_tmr == TMO);
  // The timer saturates so a very long wait can never alias back to a small value.
  assign w_tmr_inc = (&r_tmr) ? r_tmr : r_tmr + CNT_W'(1);

  // Marker sequencer FSM: state, timer, captured fields and all outputs.
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      r_state   <= S_IDLE;
      r_st_mm   <= 1'b0;
      r_qid     <= '0;
      r_tmr     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_timeout <= 1'b0;
      r_latency <= '0;
      r_cnt     <= '0;
      r_mm_req  <= 1'b0;
      r_st_req  <= 1'b0;
      r_hold    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // Responses that arrive here belong to no operation and are dropped.
          if (csr_mrkr_start) begin
            r_st_mm   <= csr_mrkr_st_mm;
            r_qid     <= csr_mrkr_qid;
            r_timeout <= 1'b0;
            r_tmr     <= '0;
            r_busy    <= 1'b1;
            r_hold    <= 1'b1;
            r_state   <= S_HOLD;
          end
        end
        S_HOLD: begin
          // One fenced cycle lets a descriptor handshake already in flight drain
          // before the marker is presented. The timer counts the REQ entry
          // cycle as cycle 1.
          r_tmr    <= w_tmr_inc;
          r_mm_req <= r_st_mm;
          r_st_req <= ~r_st_mm;
          r_state  <= S_REQ;
        end
        S_REQ: begin
          r_tmr <= w_tmr_inc;
          if (w_tmo) begin
            r_mm_req  <= 1'b0;
            r_st_req  <= 1'b0;
            r_hold    <= 1'b0;
            r_busy    <= 1'b0;
            r_timeout <= 1'b1;
            r_done    <= 1'b1;
            r_state   <= S_IDLE;
          end else if (w_sel_rdy) begin
            r_mm_req <= 1'b0;
            r_st_req <= 1'b0;
            r_hold   <= 1'b0;
            r_state  <= S_WAIT_RSP;
          end
        end
        S_WAIT_RSP: begin
          r_tmr <= w_tmr_inc;
          // A response in the same cycle as the timeout still counts as success.
          if (w_sel_rsp) begin
            r_latency <= r_tmr;
            r_cnt     <= r_cnt + CNT_W'(1);
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
            r_state   <= S_IDLE;
          end else if (w_tmo) begin
            r_busy    <= 1'b0;
            r_timeout <= 1'b1;
            r_done    <= 1'b1;
            r_state   <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign csr_mrkr_busy     = r_busy;
  assign csr_mrkr_done     = r_done;
  assign csr_mrkr_timeout  = r_timeout;
  assign csr_mrkr_latency  = r_latency;
  assign csr_mrkr_cnt      = r_cnt;
  assign h2c_mm_marker_req = r_mm_req;
  assign h2c_st_marker_req = r_st_req;
  assign h2c_mrkr_qid      = r_qid;
  assign h2c_dsc_byp_hold  = r_hold;

endmodule

// File: tb/tb_h2c_marker_ctrl.sv
// Directed bench for h2c_marker_ctrl with a done-driven scoreboard.
// The main instance uses TIMEOUT=20. A narrow-counter instance exercises
// counter wrap in a short run.
module tb_h2c_marker_ctrl;

  logic axi_aclk = 1'b0;
  always #5 axi_aclk = ~axi_aclk;

  logic axi_aresetn;

  // main instance signals
  logic        start, st_mm, mm_rdy, st_rdy, mm_rsp, st_rsp;
  logic [10:0] qid;
  logic        busy, done, timeout, mm_req, st_req, hold;
  logic [15:0] latency, cnt;
  logic [10:0] mqid;

  // narrow-counter instance signals
  logic        s_start, s_st_mm, s_mm_rdy, s_st_rdy, s_mm_rsp, s_st_rsp;
  logic [10:0] s_qid;
  logic        s_busy, s_done, s_timeout, s_mm_req, s_st_req, s_hold;
  logic [3:0]  s_latency, s_cnt;
  logic [10:0] s_mqid;

  h2c_marker_ctrl #(.CNT_W(16), .TIMEOUT(20)) dut (
    .axi_aclk(axi_aclk), .axi_aresetn(axi_aresetn),
    .csr_mrkr_start(start), .csr_mrkr_st_mm(st_mm), .csr_mrkr_qid(qid),
    .csr_mrkr_busy(busy), .csr_mrkr_done(done), .csr_mrkr_timeout(timeout),
    .csr_mrkr_latency(latency), .csr_mrkr_cnt(cnt),
    .h2c_mm_marker_req(mm_req), .h2c_st_marker_req(st_req),
    .h2c_mrkr_qid(mqid), .h2c_dsc_byp_hold(hold),
    .h2c_byp_in_mm_rdy(mm_rdy), .h2c_byp_in_st_rdy(st_rdy),
    .h2c_mm_marker_rsp(mm_rsp), .h2c_st_marker_rsp(st_rsp)
  );

  h2c_marker_ctrl #(.CNT_W(4), .TIMEOUT(15)) dut_small (
    .axi_aclk(axi_aclk), .axi_aresetn(axi_aresetn),
    .csr_mrkr_start(s_start), .csr_mrkr_st_mm(s_st_mm), .csr_mrkr_qid(s_qid),
    .csr_mrkr_busy(s_busy), .csr_mrkr_done(s_done), .csr_mrkr_timeout(s_timeout),
    .csr_mrkr_latency(s_latency), .csr_mrkr_cnt(s_cnt),
    .h2c_mm_marker_req(s_mm_req), .h2c_st_marker_req(s_st_req),
    .h2c_mrkr_qid(s_mqid), .h2c_dsc_byp_hold(s_hold),
    .h2c_byp_in_mm_rdy(s_mm_rdy), .h2c_byp_in_st_rdy(s_st_rdy),
    .h2c_mm_marker_rsp(s_mm_rsp), .h2c_st_marker_rsp(s_st_rsp)
  );

  typedef struct packed {
    logic        to;
    logic [15:0] lat;
    logic [15:0] cnt;
    logic [10:0] qid;
  } exp_t;

  exp_t sb_q[$];
  exp_t sb_e;

  int n_vec = 0;
  int n_err = 0;
  int hold_n, mmreq_n, streq_n, done_n;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge axi_aclk);
      #1;
    end
  endtask

  task automatic clr_counts();
    hold_n  = 0;
    mmreq_n = 0;
    streq_n = 0;
    done_n  = 0;
  endtask

  task automatic chk_zero(input string p);
    chk({p, "_busy"},    32'(busy),    32'h0);
    chk({p, "_done"},    32'(done),    32'h0);
    chk({p, "_timeout"}, 32'(timeout), 32'h0);
    chk({p, "_latency"}, 32'(latency), 32'h0);
    chk({p, "_cnt"},     32'(cnt),     32'h0);
    chk({p, "_mm_req"},  32'(mm_req),  32'h0);
    chk({p, "_st_req"},  32'(st_req),  32'h0);
    chk({p, "_qid"},     32'(mqid),    32'h0);
    chk({p, "_hold"},    32'(hold),    32'h0);
  endtask

  // Sample away from the active edge; pop one expected result per done pulse.
  always @(negedge axi_aclk) begin
    if (hold)   hold_n++;
    if (mm_req) mmreq_n++;
    if (st_req) streq_n++;
    if (done) begin
      done_n++;
      chk("sb_done_expected", 32'(sb_q.size() != 0), 32'h1);
      if (sb_q.size() != 0) begin
        sb_e = sb_q.pop_front();
        chk("sb_timeout", 32'(timeout), 32'(sb_e.to));
        chk("sb_latency", 32'(latency), 32'(sb_e.lat));
        chk("sb_cnt",     32'(cnt),     32'(sb_e.cnt));
        chk("sb_qid",     32'(mqid),    32'(sb_e.qid));
        chk("sb_busy_low", 32'(busy),   32'h0);
      end
    end
  end

  initial begin
    {start, st_mm, mm_rdy, st_rdy, mm_rsp, st_rsp} = '0;
    qid = '0;
    {s_start, s_st_mm, s_mm_rdy, s_st_rdy, s_mm_rsp, s_st_rsp} = '0;
    s_qid = '0;
    clr_counts();

    // reset
    axi_aresetn = 1'b1;
    #2 axi_aresetn = 1'b0;
    tick(3);
    chk_zero("rst0");
    chk("rst0_small_cnt", 32'(s_cnt), 32'h0);
    chk("rst0_small_busy", 32'(s_busy), 32'h0);
    axi_aresetn = 1'b1;
    tick(1);

    // 1: MM happy path
    clr_counts();
    st_mm = 1'b1; qid = 11'h05A; mm_rdy = 1'b1; start = 1'b1;
    tick(); start = 1'b0;
    chk("t1_busy", 32'(busy), 32'h1);
    chk("t1_hold_in_hold", 32'(hold), 32'h1);
    chk("t1_mmreq_in_hold", 32'(mm_req), 32'h0);
    tick();
    chk("t1_mmreq", 32'(mm_req), 32'h1);
    chk("t1_streq", 32'(st_req), 32'h0);
    chk("t1_qid", 32'(mqid), 32'h05A);
    tick();
    chk("t1_mmreq_drop", 32'(mm_req), 32'h0);
    chk("t1_hold_drop", 32'(hold), 32'h0);
    tick(4);
    mm_rsp = 1'b1;
    sb_q.push_back('{to: 1'b0, lat: 16'd6, cnt: 16'd1, qid: 11'h05A});
    tick(); mm_rsp = 1'b0;
    chk("t1_done", 32'(done), 32'h1);
    tick();
    chk("t1_done_single", 32'(done), 32'h0);
    tick();
    chk("t1_hold_cycles", 32'(hold_n), 32'd2);
    chk("t1_mmreq_cycles", 32'(mmreq_n), 32'd1);
    chk("t1_streq_cycles", 32'(streq_n), 32'd0);
    chk("t1_done_count", 32'(done_n), 32'd1);

    // 2: ST with backpressure, spurious MM response
    clr_counts();
    st_mm = 1'b0; qid = 11'h123; st_rdy = 1'b0; mm_rdy = 1'b1; start = 1'b1;
    tick(); start = 1'b0;
    tick();
    chk("t2_streq", 32'(st_req), 32'h1);
    chk("t2_mmreq_off", 32'(mm_req), 32'h0);
    tick(10);
    chk("t2_streq_held", 32'(st_req), 32'h1);
    st_rdy = 1'b1;
    tick(); st_rdy = 1'b0;
    chk("t2_streq_drop", 32'(st_req), 32'h0);
    mm_rsp = 1'b1;
    tick(); mm_rsp = 1'b0;
    chk("t2_spurious_busy", 32'(busy), 32'h1);
    st_rsp = 1'b1;
    sb_q.push_back('{to: 1'b0, lat: 16'd13, cnt: 16'd2, qid: 11'h123});
    tick(); st_rsp = 1'b0;
    tick(2);
    chk("t2_streq_cycles", 32'(streq_n), 32'd11);
    chk("t2_hold_cycles", 32'(hold_n), 32'd12);
    chk("t2_mmreq_cycles", 32'(mmreq_n), 32'd0);
    chk("t2_done_count", 32'(done_n), 32'd1);

    // 3: timeout, no response
    clr_counts();
    st_mm = 1'b1; qid = 11'h200; mm_rdy = 1'b1; start = 1'b1;
    sb_q.push_back('{to: 1'b1, lat: 16'd13, cnt: 16'd2, qid: 11'h200});
    tick(); start = 1'b0;
    tick(20);
    chk("t3_busy_pre", 32'(busy), 32'h1);
    chk("t3_done_pre", 32'(done), 32'h0);
    tick();
    chk("t3_done", 32'(done), 32'h1);
    chk("t3_timeout", 32'(timeout), 32'h1);
    tick();
    chk("t3_timeout_sticky", 32'(timeout), 32'h1);
    tick();
    chk("t3_done_count", 32'(done_n), 32'd1);

    // 4: response collides with timeout; new start clears timeout
    clr_counts();
    st_mm = 1'b0; qid = 11'h3C3; st_rdy = 1'b1; start = 1'b1;
    tick(); start = 1'b0;
    chk("t4_timeout_cleared", 32'(timeout), 32'h0);
    tick(2);
    tick(18);
    st_rsp = 1'b1;
    sb_q.push_back('{to: 1'b0, lat: 16'd20, cnt: 16'd3, qid: 11'h3C3});
    tick(); st_rsp = 1'b0;
    chk("t4_done", 32'(done), 32'h1);
    chk("t4_timeout", 32'(timeout), 32'h0);
    tick(2);

    // 5a: start while busy is ignored
    clr_counts();
    st_mm = 1'b1; qid = 11'h0AA; mm_rdy = 1'b1; start = 1'b1;
    tick(); start = 1'b0;
    tick(2);
    start = 1'b1; st_mm = 1'b0; qid = 11'h7FF;
    tick(); start = 1'b0;
    chk("t5_qid_kept", 32'(mqid), 32'h0AA);
    chk("t5_busy", 32'(busy), 32'h1);
    chk("t5_streq_off", 32'(st_req), 32'h0);
    mm_rsp = 1'b1;
    sb_q.push_back('{to: 1'b0, lat: 16'd3, cnt: 16'd4, qid: 11'h0AA});
    tick(); mm_rsp = 1'b0;
    tick(2);

    // 5b: reset while in REQ
    clr_counts();
    st_mm = 1'b0; qid = 11'h155; st_rdy = 1'b0; start = 1'b1;
    tick(); start = 1'b0;
    tick();
    chk("t5_in_req", 32'(st_req), 32'h1);
    #2 axi_aresetn = 1'b0;
    #1;
    chk_zero("t5_async");
    tick(2);
    axi_aresetn = 1'b1;
    tick(3);
    chk_zero("t5_post");
    chk("t5_no_done", 32'(done_n), 32'd0);

    // 6: completion counter wrap on the narrow instance
    s_st_mm = 1'b1; s_mm_rdy = 1'b1;
    for (int i = 0; i < 16; i++) begin
      s_start = 1'b1;
      tick(); s_start = 1'b0;
      tick(2);
      s_mm_rsp = 1'b1;
      tick(); s_mm_rsp = 1'b0;
      tick();
      if (i == 14) begin
        chk("t6_cnt_max", 32'(s_cnt), 32'hF);
        chk("t6_latency", 32'(s_latency), 32'h2);
      end
    end
    chk("t6_cnt_wrap", 32'(s_cnt), 32'h0);
    chk("t6_timeout", 32'(s_timeout), 32'h0);

    chk("sb_drained", 32'(sb_q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
